// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if: bus between the DRAM port arbiter and its requesters plus the DRAM.
// Port A is the processor and port B the host loader/readback engine. mem_* connect to the DRAM.
// The master modport is the environment: the requesters and the DRAM.
// The slave modport is the arbiter.
interface dram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_req, b_we, b_gnt, b_rvalid, b_lock, b_owned;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_q;
  logic              mem_wren;
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, b_lock, mem_q,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, b_owned, mem_addr, mem_wdata, mem_wren
  );
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, b_lock, mem_q,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, b_owned, mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares the single-port DRAM between the core (A) and the host engine (B).
// Ports:
//   clock  divided system clock
//   rst    asynchronous active-high reset
//   bus    dram_port_arbiter_if.slave
//          A and B each have req/we/addr/wdata in and gnt/rvalid/rdata out.
//          B also has b_lock in and b_owned out.
//          The DRAM side is mem_addr/mem_wdata/mem_wren out and mem_q in.
// Read data returns two cycles after the grant edge. A B grant with b_lock held gives B the
// memory exclusively until b_lock drops.
// Define DRAM_ARB_RR_EN for round-robin tie breaking. Otherwise A has fixed priority on ties.
module dram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input logic clock,
  input logic rst,
  dram_port_arbiter_if.slave bus
);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t state;
  logic s1_v, s1_p, s2_v, s2_p;
  logic hold, prio_a, a_win, b_win;
`ifdef DRAM_ARB_RR_EN
  logic last_a;
  assign prio_a = !last_a;
`else
  assign prio_a = 1'b1;
`endif
  // While locked and b_lock still high, A is not a candidate at all.
  always_comb begin
    hold = state == LOCKED && bus.b_lock;
    a_win = !hold && bus.a_req && (!bus.b_req || prio_a);
    b_win = bus.b_req && !a_win;
  end
  assign bus.a_rdata = bus.mem_q;
  assign bus.b_rdata = bus.mem_q;
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= ARB;
      bus.b_owned <= 1'b0;
      bus.a_gnt <= 1'b0;
      bus.b_gnt <= 1'b0;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.mem_wren <= 1'b0;
      bus.mem_addr <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      s1_v <= 1'b0;
      s1_p <= 1'b0;
      s2_v <= 1'b0;
      s2_p <= 1'b0;
`ifdef DRAM_ARB_RR_EN
      last_a <= 1'b1;
`endif
    end else begin
      bus.a_gnt <= a_win;
      bus.b_gnt <= b_win;
      if (a_win || b_win) begin
        bus.mem_addr <= a_win ? bus.a_addr : bus.b_addr;
        bus.mem_wdata <= a_win ? bus.a_wdata : bus.b_wdata;
      end
      bus.mem_wren <= a_win ? bus.a_we : b_win && bus.b_we;
      // The read tag carries only reads. Port 1 means B.
      s1_v <= (a_win && !bus.a_we) || (b_win && !bus.b_we);
      s1_p <= b_win;
      s2_v <= s1_v;
      s2_p <= s1_p;
      bus.a_rvalid <= s2_v && !s2_p;
      bus.b_rvalid <= s2_v && s2_p;
      state <= (b_win && bus.b_lock) || hold ? LOCKED : ARB;
      bus.b_owned <= (b_win && bus.b_lock) || hold;
`ifdef DRAM_ARB_RR_EN
      if (a_win || b_win) last_a <= a_win;
`endif
    end
  end
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: checks the arbiter against a transaction-level model of ports A/B and the DRAM.
module tb_dram_port_arbiter;
  logic clock = 1'b0;
  logic rst = 1'b0;
  always #5 clock = ~clock;
  dram_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();
  dram_port_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (.clock(clock), .rst(rst), .bus(bus));
  // The DRAM has a registered address and a registered output, so q appears two edges after the grant.
  logic [7:0] dram [0:255];
  logic [7:0] mm [0:255];
  logic [7:0] rd1;
  always @(posedge clock) begin
    if (bus.mem_wren) dram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    rd1 <= dram[bus.mem_addr[7:0]];
    bus.mem_q <= rd1;
  end
  typedef struct {logic a, b, own, wren; logic [15:0] addr; logic [7:0] wdata;} gexp_t;
  typedef struct {logic [7:0] data; int due;} rexp_t;
  gexp_t gq[$];
  rexp_t rqa[$], rqb[$];
  int cyc = 0, n_vec = 0, n_bad = 0;
  bit m_own = 1'b0, m_last_a = 1'b1, started = 1'b0;
  logic [15:0] m_addr = 16'h0;
  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  // The model picks a winner from the candidate set at each edge, then records the expected grant, the owner
  // and the bus values. It applies writes to mm in grant order and schedules read data two cycles after the grant.
  always @(posedge clock) begin
    gexp_t g;
    rexp_t r;
    bit a_c, b_c, a_w, b_w, we;
    logic [7:0] wd;
    if (!rst) begin
      cyc++;
      started = 1'b1;
      b_c = bus.b_req;
      a_c = bus.a_req && !(m_own && bus.b_lock);
`ifdef DRAM_ARB_RR_EN
      a_w = (a_c && b_c) ? !m_last_a : a_c;
`else
      a_w = a_c;
`endif
      b_w = b_c && !a_w;
      we = 1'b0;
      wd = 8'h0;
      if (a_w || b_w) begin
        m_last_a = a_w;
        we = a_w ? bus.a_we : bus.b_we;
        wd = a_w ? bus.a_wdata : bus.b_wdata;
        m_addr = a_w ? bus.a_addr : bus.b_addr;
        if (we) mm[m_addr[7:0]] = wd;
        else begin
          r.data = mm[m_addr[7:0]];
          r.due = cyc + 2;
          if (a_w) rqa.push_back(r); else rqb.push_back(r);
        end
      end
      m_own = b_w ? bus.b_lock : m_own && bus.b_lock;
      g.a = a_w;
      g.b = b_w;
      g.own = m_own;
      g.wren = (a_w || b_w) && we;
      g.addr = m_addr;
      g.wdata = wd;
      gq.push_back(g);
    end
  end
  // The monitor compares DUT outputs against the queues on the opposite clock edge.
  always @(negedge clock) begin
    gexp_t g;
    bit ea, eb;
    if (!rst && started) begin
      if (gq.size() == 0) chk("grant_queue", 16'd0, 16'd1);
      else begin
        g = gq.pop_front();
        chk("a_gnt", 16'(bus.a_gnt), 16'(g.a));
        chk("b_gnt", 16'(bus.b_gnt), 16'(g.b));
        chk("b_owned", 16'(bus.b_owned), 16'(g.own));
        chk("mem_wren", 16'(bus.mem_wren), 16'(g.wren));
        chk("mem_addr", bus.mem_addr, g.addr);
        if (g.a || g.b) chk("mem_wdata", 16'(bus.mem_wdata), 16'(g.wdata));
      end
      ea = rqa.size() > 0 && rqa[0].due == cyc;
      eb = rqb.size() > 0 && rqb[0].due == cyc;
      chk("a_rvalid", 16'(bus.a_rvalid), 16'(ea));
      chk("b_rvalid", 16'(bus.b_rvalid), 16'(eb));
      if (ea) begin
        chk("a_rdata", 16'(bus.a_rdata), 16'(rqa[0].data));
        void'(rqa.pop_front());
      end
      if (eb) begin
        chk("b_rdata", 16'(bus.b_rdata), 16'(rqb[0].data));
        void'(rqb.pop_front());
      end
    end
  end
  task automatic rst_chk();
    chk("rst_a_gnt", 16'(bus.a_gnt), 16'd0);
    chk("rst_b_gnt", 16'(bus.b_gnt), 16'd0);
    chk("rst_a_rvalid", 16'(bus.a_rvalid), 16'd0);
    chk("rst_b_rvalid", 16'(bus.b_rvalid), 16'd0);
    chk("rst_b_owned", 16'(bus.b_owned), 16'd0);
    chk("rst_mem_wren", 16'(bus.mem_wren), 16'd0);
    chk("rst_mem_addr", bus.mem_addr, 16'd0);
    chk("rst_mem_wdata", 16'(bus.mem_wdata), 16'd0);
  endtask
  // Present one access and hold it until the grant is seen, within a bounded number of cycles.
  task automatic acc(bit p, bit we, logic [15:0] ad, logic [7:0] d);
    int k = 0;
    if (p) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = ad; bus.b_wdata = d;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = ad; bus.a_wdata = d;
    end
    do begin
      @(negedge clock);
      k++;
    end while (!(p ? bus.b_gnt : bus.a_gnt) && k < 40);
    chk(p ? "b_grant_wait" : "a_grant_wait", 16'(p ? bus.b_gnt : bus.a_gnt), 16'd1);
    if (p) bus.b_req = 1'b0; else bus.a_req = 1'b0;
  endtask
  initial begin
    logic [7:0] v;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.b_lock = 0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      dram[i] = v;
      mm[i] = v;
    end
    dram[5] = 8'h3C;
    mm[5] = 8'h3C;
    #1 rst = 1'b1;
    #1 rst_chk();
    @(negedge clock);
    @(negedge clock);
    #1 rst = 1'b0;
    // Both ports request for four edges. RR starts with B favoured, so the order is B,A,B,A. Fixed priority gives A every time.
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0001;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
`ifdef DRAM_ARB_RR_EN
      chk("tie_b_gnt", 16'(bus.b_gnt), 16'(i % 2 == 0));
      chk("tie_a_gnt", 16'(bus.a_gnt), 16'(i % 2 != 0));
`else
      chk("tie_b_gnt", 16'(bus.b_gnt), 16'd0);
      chk("tie_a_gnt", 16'(bus.a_gnt), 16'd1);
`endif
    end
    bus.a_req = 0; bus.b_req = 0;
    repeat (4) @(negedge clock);
    acc(0, 0, 16'h0005, 8'h00);
    repeat (4) @(negedge clock);
    acc(1, 1, 16'h0010, 8'hA5);
    acc(0, 0, 16'h0010, 8'h00);
    repeat (4) @(negedge clock);
    // B takes the lock while A is held off, then releases it.
    bus.b_lock = 1;
    acc(1, 1, 16'h0020, 8'h11);
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0020;
    acc(1, 1, 16'h0021, 8'h22);
    acc(1, 1, 16'h0022, 8'h33);
    bus.b_lock = 0;
    @(negedge clock);
    chk("a_gnt_after_unlock", 16'(bus.a_gnt), 16'd1);
    bus.a_req = 0;
    repeat (4) @(negedge clock);
    for (int i = 1; i <= 4; i++) acc(0, 0, 16'(i), 8'h00);
    repeat (4) @(negedge clock);
    // Reset arrives after the grant, before the read data returns.
    acc(0, 0, 16'h0007, 8'h00);
    @(posedge clock);
    #2 rst = 1'b1;
    #1 rst_chk();
    gq.delete(); rqa.delete(); rqb.delete();
    m_own = 1'b0; m_last_a = 1'b1; m_addr = 16'h0;
    @(negedge clock);
    @(negedge clock);
    #1 rst = 1'b0;
    repeat (5) @(negedge clock);
    repeat (3000) begin
      @(negedge clock);
      if (!bus.a_req || bus.a_gnt) begin
        bus.a_req = $urandom_range(3) != 0;
        bus.a_we = 1'($urandom_range(1));
        bus.a_addr = 16'($urandom_range(63));
        bus.a_wdata = 8'($urandom);
      end
      if (!bus.b_req || bus.b_gnt) begin
        bus.b_req = $urandom_range(3) != 0;
        bus.b_we = 1'($urandom_range(1));
        bus.b_addr = 16'($urandom_range(63));
        bus.b_wdata = 8'($urandom);
      end
      if ($urandom_range(7) == 0) bus.b_lock = !bus.b_lock;
    end
    @(negedge clock);
    bus.a_req = 0; bus.b_req = 0; bus.b_lock = 0;
    repeat (6) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
